// File: rtl/cva6v_vector_mem_bank_if.sv
// Request/response bundle between the vector fabric and one memory bank.
// q-channel carries requests in, p-channel carries responses back.
interface cva6v_vector_mem_bank_if #(
    parameter int unsigned MemAddrWidth = 10,
    parameter int unsigned DataWidth    = 64,
    parameter int unsigned UserWidth    = 1
);
    logic                      q_valid_i;
    logic                      q_ready_o;
    logic [MemAddrWidth-1:0]   q_addr_i;
    logic                      q_write_i;
    logic [DataWidth-1:0]      q_data_i;
    logic [DataWidth/8-1:0]    q_strb_i;
    logic [UserWidth-1:0]      q_user_i;
    logic                      p_valid_o;
    logic [DataWidth-1:0]      p_data_o;
    logic [UserWidth-1:0]      p_user_o;
    logic                      p_err_o;

    modport master (
        output q_valid_i, q_addr_i, q_write_i, q_data_i, q_strb_i, q_user_i,
        input  q_ready_o, p_valid_o, p_data_o, p_user_o, p_err_o
    );

    modport slave (
        input  q_valid_i, q_addr_i, q_write_i, q_data_i, q_strb_i, q_user_i,
        output q_ready_o, p_valid_o, p_data_o, p_user_o, p_err_o
    );
endinterface

// File: rtl/cva6v_vector_mem_bank.sv
// Single-bank memory responder: zero-fill after reset, then one request
// per cycle with read-before-write and a fixed-latency response pipeline.
module cva6v_vector_mem_bank #(
    parameter int unsigned NumWords              = 1024,
    parameter int unsigned MemAddrWidth          = 10,
    parameter int unsigned DataWidth             = 64,
    parameter int unsigned UserWidth             = 1,
    parameter int unsigned MemoryResponseLatency = 1,
    parameter bit          InitZero              = 1'b1
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    cva6v_vector_mem_bank_if.slave bus
);
    localparam int unsigned IdxW  = $clog2(NumWords);
    localparam int unsigned StrbW = DataWidth / 8;
    localparam int unsigned Lat   = MemoryResponseLatency;

    typedef enum logic {StInit, StServe} state_e;

    state_e                 state_q, state_d;
    logic [IdxW-1:0]        cnt_q, cnt_d;
    logic [DataWidth-1:0]   mem_q [NumWords];

    logic [Lat-1:0]         vld_q, vld_d;
    logic [DataWidth-1:0]   data_q [Lat];
    logic [DataWidth-1:0]   data_d [Lat];
    logic [UserWidth-1:0]   user_q [Lat];
    logic [UserWidth-1:0]   user_d [Lat];
    logic [Lat-1:0]         err_q, err_d;

    logic                   accept;
    logic                   in_range;
    logic                   wr_en;
    logic [IdxW-1:0]        idx;
    logic [IdxW-1:0]        wr_idx;
    logic [DataWidth-1:0]   rd_word;
    logic [DataWidth-1:0]   wr_word;
    logic                   out_v;

    assign bus.q_ready_o = (state_q == StServe) & ~rst_i;

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        wr_en    = 1'b0;
        wr_idx   = cnt_q;
        wr_word  = '0;
        idx      = bus.q_addr_i[IdxW-1:0];
        // Full-width compare: upper address bits never alias into the bank.
        in_range = {1'b0, bus.q_addr_i} < (MemAddrWidth+1)'(NumWords);
        accept   = bus.q_valid_i & bus.q_ready_o;
        rd_word  = in_range ? mem_q[idx] : '0;
        unique case (state_q)
            StInit: begin
                wr_en = 1'b1;
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == IdxW'(NumWords - 1)) begin
                    state_d = StServe;
                    cnt_d   = '0;
                end
            end
            StServe: begin
                if (accept && bus.q_write_i && in_range) begin
                    wr_en  = 1'b1;
                    wr_idx = idx;
                    for (int b = 0; b < StrbW; b++) begin
                        wr_word[b*8 +: 8] = bus.q_strb_i[b] ? bus.q_data_i[b*8 +: 8]
                                                            : rd_word[b*8 +: 8];
                    end
                end
            end
            default: ;
        endcase
        if (rst_i) wr_en = 1'b0;
    end

    always_comb begin
        vld_d     = '0;
        err_d     = '0;
        vld_d[0]  = accept;
        data_d[0] = accept ? rd_word : '0;
        user_d[0] = accept ? bus.q_user_i : '0;
        err_d[0]  = accept & ~in_range;
        for (int i = 1; i < Lat; i++) begin
            vld_d[i]  = vld_q[i-1];
            data_d[i] = data_q[i-1];
            user_d[i] = user_q[i-1];
            err_d[i]  = err_q[i-1];
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= InitZero ? StInit : StServe;
            cnt_q   <= '0;
            vld_q   <= '0;
            err_q   <= '0;
            for (int i = 0; i < Lat; i++) begin
                data_q[i] <= '0;
                user_q[i] <= '0;
            end
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            vld_q   <= vld_d;
            err_q   <= err_d;
            for (int i = 0; i < Lat; i++) begin
                data_q[i] <= data_d[i];
                user_q[i] <= user_d[i];
            end
        end
    end

    // Array has no reset; contents are cleared by the INIT sweep instead.
    always_ff @(posedge clk_i) begin
        if (wr_en) mem_q[wr_idx] <= wr_word;
    end

    assign out_v         = vld_q[Lat-1] & ~rst_i;
    assign bus.p_valid_o = out_v;
    assign bus.p_data_o  = out_v ? data_q[Lat-1] : '0;
    assign bus.p_user_o  = out_v ? user_q[Lat-1] : '0;
    assign bus.p_err_o   = out_v & err_q[Lat-1];
endmodule

// File: tb/tb_cva6v_vector_mem_bank.sv
// Randomized and directed bench for the memory bank against a
// transaction-level model (word array plus timed response queue).
module tb_cva6v_vector_mem_bank;
    localparam int NW  = 12;
    localparam int AW  = 5;
    localparam int DW  = 64;
    localparam int UW  = 4;
    localparam int LAT = 3;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    cva6v_vector_mem_bank_if #(
        .MemAddrWidth(AW), .DataWidth(DW), .UserWidth(UW)
    ) bus ();

    cva6v_vector_mem_bank #(
        .NumWords(NW), .MemAddrWidth(AW), .DataWidth(DW),
        .UserWidth(UW), .MemoryResponseLatency(LAT), .InitZero(1'b1)
    ) dut (
        .clk_i(clk),
        .rst_i(rst),
        .bus(bus)
    );

    typedef struct {
        int            due;
        logic [DW-1:0] data;
        logic [UW-1:0] user;
        logic          err;
    } resp_t;

    resp_t         rq[$];
    logic [DW-1:0] mem[NW];
    int            init_left = 0;
    int            edges = 0;
    int            nchk = 0;
    int            nfail = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        nchk++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL %s @edge %0d: observed %0h expected %0h", tag, edges, obs, exp);
        end
    endtask

    task automatic step();
        resp_t         r;
        int            a;
        logic          ev;
        logic [DW-1:0] ed;
        logic [UW-1:0] eu;
        logic          ee;
        @(posedge clk);
        edges++;
        if (rst) begin
            rq.delete();
            init_left = NW;
        end else if (init_left > 0) begin
            mem[NW-init_left] = '0;
            init_left--;
        end else if (bus.q_valid_i) begin
            a      = int'(bus.q_addr_i);
            r.due  = edges + LAT - 1;
            r.user = bus.q_user_i;
            r.err  = (a >= NW);
            r.data = (a < NW) ? mem[a] : '0;
            rq.push_back(r);
            if (bus.q_write_i && a < NW)
                for (int b = 0; b < DW/8; b++)
                    if (bus.q_strb_i[b]) mem[a][b*8 +: 8] = bus.q_data_i[b*8 +: 8];
        end
        @(negedge clk);
        ev = 1'b0; ed = '0; eu = '0; ee = 1'b0;
        if (!rst && rq.size() > 0 && rq[0].due == edges) begin
            ev = 1'b1; ed = rq[0].data; eu = rq[0].user; ee = rq[0].err;
            void'(rq.pop_front());
        end
        chk("q_ready", 64'(bus.q_ready_o), 64'(!rst && init_left == 0));
        chk("p_valid", 64'(bus.p_valid_o), 64'(ev));
        chk("p_data",  bus.p_data_o, ed);
        chk("p_user",  64'(bus.p_user_o), 64'(eu));
        chk("p_err",   64'(bus.p_err_o), 64'(ee));
    endtask

    task automatic req(input logic v, input logic w, input int a,
                       input logic [DW-1:0] d, input logic [DW/8-1:0] s,
                       input logic [UW-1:0] u);
        bus.q_valid_i = v;
        bus.q_write_i = w;
        bus.q_addr_i  = AW'(a);
        bus.q_data_i  = d;
        bus.q_strb_i  = s;
        bus.q_user_i  = u;
        step();
    endtask

    task automatic junk();
        req(1'b1, 1'b1, int'($urandom_range(0, NW-1)),
            {$urandom, $urandom}, 8'hFF, UW'($urandom));
    endtask

    initial begin
        rst = 1'b1;
        req(1'b0, 1'b0, 0, '0, '0, '0);
        step();
        step();
        rst = 1'b0;
        // INIT window: junk writes must be ignored
        for (int i = 0; i < NW; i++) junk();
        for (int i = 0; i < NW; i++) req(1'b1, 1'b0, i, '0, '0, UW'(i));
        // write then read same address back-to-back
        req(1'b1, 1'b1, 5, 64'hDEAD_BEEF_0123_4567, 8'hFF, 4'h1);
        req(1'b1, 1'b0, 5, '0, '0, 4'h2);
        // strobe merge and strb=0 write
        req(1'b1, 1'b1, 7, 64'h1111_1111_1111_1111, 8'hFF, 4'h3);
        req(1'b1, 1'b1, 7, 64'hFFFF_FFFF_FFFF_FFFF, 8'h0F, 4'h4);
        req(1'b1, 1'b0, 7, '0, '0, 4'h5);
        req(1'b1, 1'b1, 7, 64'hA5A5_A5A5_A5A5_A5A5, 8'h00, 4'h6);
        req(1'b1, 1'b0, 7, '0, '0, 4'h7);
        // out of range
        req(1'b1, 1'b0, NW, '0, '0, 4'h8);
        req(1'b1, 1'b1, NW, {$urandom, $urandom}, 8'hFF, 4'h9);
        req(1'b1, 1'b1, 31, {$urandom, $urandom}, 8'hFF, 4'hA);
        req(1'b1, 1'b1, 16, {$urandom, $urandom}, 8'hFF, 4'hB);
        for (int i = 0; i < NW; i++) req(1'b1, 1'b0, i, '0, '0, UW'(i));
        // back-to-back reads, user 0..7
        for (int i = 0; i < 8; i++) req(1'b1, 1'b0, i, '0, '0, UW'(i));
        for (int i = 0; i < LAT; i++) req(1'b0, 1'b0, 0, '0, '0, '0);
        // randomized traffic
        for (int i = 0; i < 300; i++) begin
            req(1'($urandom_range(0, 3) != 0), 1'($urandom),
                ($urandom_range(0, 9) == 0) ? int'($urandom_range(NW, 31))
                                            : int'($urandom_range(0, NW-1)),
                {$urandom, $urandom}, 8'($urandom), UW'($urandom));
        end
        // reset with reads in flight and a write in the reset cycle
        req(1'b1, 1'b0, 3, '0, '0, 4'hC);
        req(1'b1, 1'b0, 4, '0, '0, 4'hD);
        rst = 1'b1;
        req(1'b1, 1'b1, 0, 64'h0123_4567_89AB_CDEF, 8'hFF, 4'hE);
        rst = 1'b0;
        for (int i = 0; i < NW; i++) junk();
        for (int i = 0; i < 100; i++) begin
            req(1'b1, 1'($urandom), int'($urandom_range(0, NW)),
                {$urandom, $urandom}, 8'($urandom), UW'($urandom));
        end
        for (int i = 0; i < NW; i++) req(1'b1, 1'b0, i, '0, '0, UW'(i));
        for (int i = 0; i < LAT + 1; i++) req(1'b0, 1'b0, 0, '0, '0, '0);
        $display("%0d/%0d checks passed", nchk - nfail, nchk);
        $finish;
    end
endmodule
